onn_phase_loader: RTL and testbench
===================================

# onn_phase_loader

Sequencer for the serial phase-state chain of the ONN neuron array. On `start` it shifts a parallel vector of initial neuron phases bit-serially into the daisy-chained per-neuron state registers, generating the `full_tick` shift strobe itself. In the same pass it captures the bits leaving the chain tail, so the previous phases of every neuron are read back as the new ones are written (swap). It sits between the host/config logic and neuron 0's serial state input.

## Interface
- `N_NEURON`, 8: number of neurons on the chain; ≥1.
- `PHASE_W`, 4: phase bits per neuron. Each chain stage holds `STAGE_D = PHASE_W+1` flops: the phase bits plus one registered serial-out flop. `STAGE_D` is derived, not overridable.
- `TICK_DIV`, 4: clock cycles per shift tick; ≥1.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a load/readback pass; sampled only in IDLE.
- `wr_phase`  in  N_NEURON*PHASE_W  new phases; neuron j at `[PHASE_W*j +: PHASE_W]`, neuron 0 nearest the controller. Sampled on the accepting edge.
- `busy`  out  1  high from the cycle after acceptance until `done`, inclusive.
- `done`  out  1  one-cycle pulse at end of pass.
- `rd_phase`  out  N_NEURON*PHASE_W  phases held by the chain before the last pass; same packing as `wr_phase`. Valid from `done`, held until the next `done`.
- `full_tick`  out  1  shift strobe to every chain stage.
- `chain_ser_out`  out  1  serial data to neuron 0 `ser_state_in`.
- `chain_ser_in`  in  1  serial data from neuron N_NEURON-1 `ser_state_out`.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `start=1` captures `wr_phase` into a shadow shift register of `L = N_NEURON*STAGE_D` bits, clears the tick divider and bit counter, and moves to SHIFT.
- Shadow order, first bit out first: for neuron j = N_NEURON-1 down to 0, emit one pad bit (0), then phase bits MSB to LSB. After L ticks, each neuron's `ini_phase[i]` holds `wr_phase` bit i and each serial-out flop holds 0.
- `chain_ser_out` is registered. It presents the first shadow bit from the cycle after acceptance and advances on the edge that ends each tick cycle.
- Readback: in every cycle with `full_tick=1`, sample `chain_ser_in`, which is the pre-shift tail value. The sampled sequence has the same layout as the emitted sequence. Pad samples are discarded; phase samples are assembled into `rd_phase` as the old contents.
- After tick L-1 (0-based), go to DONE. DONE: `done=1`, `rd_phase` updates, return to IDLE the next cycle.
- `start` in SHIFT or DONE is ignored, not queued. If held high, it is accepted on the first IDLE cycle.

## Timing
- Reset values: state IDLE, `busy=0`, `done=0`, `full_tick=0`, `chain_ser_out=0`, `rd_phase=0`, shadow register and counters 0.
- Acceptance edge E0. `full_tick` is high for exactly one cycle in cycles E0+k·TICK_DIV, k=1..L (cycle n means the cycle after edge E0+n-1). With TICK_DIV=1, `full_tick` is high continuously for L cycles.
- `done` occurs in cycle E0+L·TICK_DIV+1. A new start is accepted no earlier than edge E0+L·TICK_DIV+2.
- Exactly L ticks per pass, never more.
- `rst` mid-pass: state, outputs and counters return to reset values on that edge. No further ticks are issued. Chain contents are partially shifted and undefined; the next full pass restores a defined state.
- Tick counter width is `$clog2(L+1)`. Divider width is `$clog2(TICK_DIV)`, minimum 1.

## Structure
- Package `onn_ctrl_pkg` holds the state enum (IDLE/SHIFT/DONE) and the `PHASE_W` default constant, shared with other neuron-control blocks.
- Sub-module `tick_divider` (parameter TICK_DIV; ports clk, rst, clr, en, tick) generates `full_tick`.
- The top level holds the FSM, shadow register, readback register and bit counter.

## Test plan
The bench uses a behavioural model of N_NEURON chained stages, each stage updating `ini_phase[0]<=in`, `ini_phase[3:1]<=ini_phase[2:0]`, `out<=ini_phase[3]` on `full_tick`.
- N=2, TICK_DIV=1, model chain zeroed, `wr_phase=0xA3` → `chain_ser_out` sequence 0,1,0,1,0,0,0,0,1,1 over 10 ticks. Model neuron1=0xA, neuron0=0x3, both out flops 0. `rd_phase=0x00`. `done` in cycle 11.
- Follow-up pass with `wr_phase=0x5C` → `rd_phase=0xA3`, chain=0x5C.
- TICK_DIV=3, N=2 → 10 single-cycle ticks spaced exactly 3 cycles apart. First tick in cycle 3, `done` in cycle 31.
- `start` pulsed mid-SHIFT and during DONE → no extra ticks, single `done`. `start` held high through DONE → next pass accepted on the first IDLE edge.
- `rst` asserted after 4 ticks → next cycle `full_tick=0`, `busy=0`, `rd_phase=0`. A fresh pass with `wr_phase=0x3C` then leaves the chain at 0x3C.
- N=8, random `wr_phase` sequence over 50 passes → each `rd_phase` equals the previous `wr_phase`. Tick count is 40 per pass.

Source files
------------

// File: rtl/onn_ctrl_pkg.sv
// Shared definitions for the ONN neuron-control blocks.
package onn_ctrl_pkg;

  localparam int PHASE_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } onn_state_t;

endpackage

// File: rtl/tick_divider.sv
// Shift-strobe generator: one single-cycle tick every TICK_DIV enabled cycles,
// the first one TICK_DIV cycles after a clear.
module tick_divider #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] cnt;

  // Divider count, wrapping after the tick cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/onn_phase_loader.sv
// Load/readback sequencer for the ONN serial phase-state chain: writes new
// phases into the daisy chain while capturing the old ones from its tail.
module onn_phase_loader
  import onn_ctrl_pkg::*;
#(
  parameter int N_NEURON = 8,
  parameter int PHASE_W  = PHASE_W_DEF,
  parameter int TICK_DIV = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [N_NEURON*PHASE_W-1:0] wr_phase,
  output logic                        busy,
  output logic                        done,
  output logic [N_NEURON*PHASE_W-1:0] rd_phase,
  output logic                        full_tick,
  output logic                        chain_ser_out,
  input  logic                        chain_ser_in
);

  localparam int STAGE_D = PHASE_W + 1;
  localparam int L       = N_NEURON * STAGE_D;
  localparam int CNT_W   = $clog2(L + 1);
  localparam int VEC_W   = N_NEURON * PHASE_W;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(L - 1);

  // Each stage block is {pad, phase}; the top block (last neuron) leaves first.
  function automatic logic [L-1:0] pack_shadow(input logic [VEC_W-1:0] w);
    logic [L-1:0] s;
    s = '0;
    for (int j = 0; j < N_NEURON; j++) begin
      s[j*STAGE_D +: STAGE_D] = {1'b0, w[j*PHASE_W +: PHASE_W]};
    end
    return s;
  endfunction

  function automatic logic [VEC_W-1:0] unpack_readback(input logic [L-1:0] s);
    logic [VEC_W-1:0] r;
    r = '0;
    for (int j = 0; j < N_NEURON; j++) begin
      r[j*PHASE_W +: PHASE_W] = s[j*STAGE_D +: PHASE_W];
    end
    return r;
  endfunction

  onn_state_t       state;
  onn_state_t       state_next;
  logic             accept;
  logic             shift_en;
  logic             last_tick;
  logic             busy_next;
  logic             done_next;
  logic [L-1:0]     load_vec;
  logic [L-1:0]     rd_next;
  logic [L-2:0]     shadow;
  logic [L-2:0]     rd_shift;
  logic [CNT_W-1:0] bit_cnt;

  assign load_vec  = pack_shadow(wr_phase);
  assign rd_next   = {rd_shift, chain_ser_in};
  assign accept    = (state == IDLE) && start;
  assign shift_en  = (state == SHIFT);
  assign last_tick = full_tick && (bit_cnt == LAST_BIT);

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (shift_en),
    .tick (full_tick)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        if (last_tick) begin
          state_next = DONE;
        end else begin
          state_next = SHIFT;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM output decode, taken from the next state so the flags come out of flops.
  always_comb begin
    busy_next = 1'b0;
    done_next = 1'b0;
    case (state_next)
      IDLE: begin
        busy_next = 1'b0;
        done_next = 1'b0;
      end
      SHIFT: begin
        busy_next = 1'b1;
        done_next = 1'b0;
      end
      DONE: begin
        busy_next = 1'b1;
        done_next = 1'b1;
      end
      default: begin
        busy_next = 1'b0;
        done_next = 1'b0;
      end
    endcase
  end

  // Registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_next;
      done <= done_next;
    end
  end

  // Shadow emit, tail capture and tick counting; rd_phase lands as DONE begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow        <= '0;
      rd_shift      <= '0;
      bit_cnt       <= '0;
      chain_ser_out <= 1'b0;
      rd_phase      <= '0;
    end else if (accept) begin
      shadow        <= load_vec[L-2:0];
      chain_ser_out <= load_vec[L-1];
      rd_shift      <= '0;
      bit_cnt       <= '0;
    end else if (full_tick) begin
      shadow        <= shadow << 1;
      chain_ser_out <= shadow[L-2];
      rd_shift      <= rd_next[L-2:0];
      bit_cnt       <= bit_cnt + CNT_W'(1);
      if (last_tick) begin
        rd_phase <= unpack_readback(rd_next);
      end
    end
  end

endmodule

// File: tb/tb_onn_phase_loader.sv
// Bench for onn_phase_loader: three configurations driving a behavioural
// neuron chain, a per-cycle reference model and directed literal checks.
module tb_onn_phase_loader;

  localparam int PW = 4;
  localparam int D  = PW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v   [3];
  logic        start_v [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        tick_v  [3];
  logic        sout_v  [3];
  logic        sin_v   [3];
  logic [31:0] wr_v    [3];
  logic [31:0] rd_v    [3];
  logic [39:0] ch      [3];
  logic [7:0]  wr_a, wr_b, rd_a, rd_b;
  logic [31:0] wr_c, rd_c;
  logic        ch_clr;
  logic        chk_en;

  int errors = 0;
  int checks = 0;

  function automatic int nn_of(input int i);
    case (i)
      0:       return 2;
      1:       return 2;
      default: return 8;
    endcase
  endfunction

  function automatic int td_of(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  // b-th emitted bit: per neuron from the last one down, a 0 pad then phase MSB..LSB.
  function automatic logic emit_bit(input logic [31:0] w, input int n, input int b);
    int t;
    int j;
    t = b % D;
    j = n - 1 - (b / D);
    if (t == 0) return 1'b0;
    return w[j*PW + PW - t];
  endfunction

  // Phases held by the model chain; stage j bit p sits at ch[j*D+p].
  function automatic logic [31:0] phases_of(input logic [39:0] c, input int n);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < n; j++)
      for (int p = 0; p < PW; p++)
        r[j*PW + p] = c[j*D + p];
    return r;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s[%0d]: got %0h expected %0h", nm, i, got, exp);
    end
  endtask

  assign wr_v[0] = {24'd0, wr_a};
  assign wr_v[1] = {24'd0, wr_b};
  assign wr_v[2] = wr_c;
  assign rd_v[0] = {24'd0, rd_a};
  assign rd_v[1] = {24'd0, rd_b};
  assign rd_v[2] = rd_c;
  assign sin_v[0] = ch[0][9];
  assign sin_v[1] = ch[1][9];
  assign sin_v[2] = ch[2][39];

  onn_phase_loader #(.N_NEURON(2), .PHASE_W(PW), .TICK_DIV(1)) u_a (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .wr_phase(wr_a),
    .busy(busy_v[0]), .done(done_v[0]), .rd_phase(rd_a), .full_tick(tick_v[0]),
    .chain_ser_out(sout_v[0]), .chain_ser_in(sin_v[0]));

  onn_phase_loader #(.N_NEURON(2), .PHASE_W(PW), .TICK_DIV(3)) u_b (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .wr_phase(wr_b),
    .busy(busy_v[1]), .done(done_v[1]), .rd_phase(rd_b), .full_tick(tick_v[1]),
    .chain_ser_out(sout_v[1]), .chain_ser_in(sin_v[1]));

  onn_phase_loader #(.N_NEURON(8), .PHASE_W(PW), .TICK_DIV(4)) u_c (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .wr_phase(wr_c),
    .busy(busy_v[2]), .done(done_v[2]), .rd_phase(rd_c), .full_tick(tick_v[2]),
    .chain_ser_out(sout_v[2]), .chain_ser_in(sin_v[2]));

  // Reference model: pass position n counts cycles from acceptance (cycle 1 = after E0).
  logic        m_act  [3];
  int          m_n    [3];
  logic [31:0] m_wr   [3];
  logic [31:0] m_snap [3];
  logic [31:0] m_rd   [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ch_clr) ch[i] <= '0;
      else if (tick_v[i]) ch[i] <= {ch[i][38:0], sout_v[i]};
      if (rst_v[i]) begin
        m_act[i] <= 1'b0;
        m_n[i]   <= 0;
        m_rd[i]  <= '0;
      end else if (m_act[i]) begin
        if (m_n[i] == nn_of(i) * D * td_of(i) + 1) begin
          m_act[i] <= 1'b0;
          m_n[i]   <= 0;
        end else begin
          m_n[i] <= m_n[i] + 1;
          if (m_n[i] == nn_of(i) * D * td_of(i)) m_rd[i] <= m_snap[i];
        end
      end else if (start_v[i]) begin
        m_act[i]  <= 1'b1;
        m_n[i]    <= 1;
        m_wr[i]   <= wr_v[i];
        m_snap[i] <= phases_of(ch[i], nn_of(i));
      end
    end
  end

  int lt_c;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        lt_c = nn_of(i) * D * td_of(i);
        chk("full_tick", i, tick_v[i],
            m_act[i] && m_n[i] <= lt_c && (m_n[i] % td_of(i)) == 0);
        chk("busy", i, busy_v[i], m_act[i]);
        chk("done", i, done_v[i], m_act[i] && m_n[i] == lt_c + 1);
        chk("rd_phase", i, rd_v[i], m_rd[i]);
        if (m_act[i] && m_n[i] <= lt_c)
          chk("ser_out", i, sout_v[i], emit_bit(m_wr[i], nn_of(i), (m_n[i] - 1) / td_of(i)));
      end
    end
  end

  task automatic run_pass(input int i, input int ncyc, input int p1, input int p2,
                          output int nt, output int ndone, output int dcyc,
                          output int ft, output int bad, output logic [31:0] seq);
    nt = 0; ndone = 0; dcyc = 0; ft = 0; bad = 0; seq = '0;
    start_v[i] = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (tick_v[i]) begin
        nt++;
        seq = {seq[30:0], sout_v[i]};
        if (ft == 0) ft = k;
        if ((k % td_of(i)) != 0) bad++;
      end
      if (done_v[i]) begin
        ndone++;
        if (dcyc == 0) dcyc = k;
      end
      start_v[i] = (k == p1) || (k == p2);
    end
  endtask

  int nt, nd, dc, ft, bad, rk;
  logic [31:0] sq, prev;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_v[i]   = 1'b1;
      start_v[i] = 1'b0;
    end
    wr_a = '0; wr_b = '0; wr_c = '0;
    ch_clr = 1'b1;
    chk_en = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", i, busy_v[i], 0);
      chk("rst_done", i, done_v[i], 0);
      chk("rst_tick", i, tick_v[i], 0);
      chk("rst_sout", i, sout_v[i], 0);
      chk("rst_rd", i, rd_v[i], 0);
      rst_v[i] = 1'b0;
    end
    ch_clr = 1'b0;
    chk_en = 1'b1;

    // TICK_DIV=1 load of 0xA3 into a zeroed chain
    wr_a = 8'hA3;
    run_pass(0, 14, 0, 0, nt, nd, dc, ft, bad, sq);
    chk("a_seq", 0, sq, 32'b0101000011);
    chk("a_ticks", 0, nt, 10);
    chk("a_done_cyc", 0, dc, 11);
    chk("a_chain", 0, {22'd0, ch[0][9:0]}, 32'b0101000011);
    chk("a_rd0", 0, rd_v[0], 32'h00);

    wr_a = 8'h5C;
    run_pass(0, 14, 0, 0, nt, nd, dc, ft, bad, sq);
    chk("a_swap_rd", 0, rd_v[0], 32'hA3);
    chk("a_chain2", 0, {22'd0, ch[0][9:0]}, 32'b0010101100);
    chk("a_chain2_ph", 0, phases_of(ch[0], 2), 32'h5C);

    // start pulsed mid-shift and in DONE is ignored
    wr_a = 8'h96;
    run_pass(0, 30, 4, 11, nt, nd, dc, ft, bad, sq);
    chk("a_ign_ticks", 0, nt, 10);
    chk("a_ign_done", 0, nd, 1);

    // start held through DONE: re-accepted on the first IDLE edge
    wr_a = 8'h11;
    start_v[0] = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 11) chk("a_hold_done", 0, done_v[0], 1);
      if (k == 12) chk("a_hold_gap", 0, busy_v[0], 0);
      if (k == 13) begin
        chk("a_hold_reacc", 0, busy_v[0], 1);
        start_v[0] = 1'b0;
      end
    end
    chk("a_hold_rd", 0, rd_v[0], 32'h11);

    // TICK_DIV=3 tick spacing
    wr_b = 8'h96;
    run_pass(1, 35, 0, 0, nt, nd, dc, ft, bad, sq);
    chk("b_ticks", 1, nt, 10);
    chk("b_first", 1, ft, 3);
    chk("b_spacing", 1, bad, 0);
    chk("b_done_cyc", 1, dc, 31);
    wr_b = 8'h5A;
    run_pass(1, 35, 0, 0, nt, nd, dc, ft, bad, sq);
    chk("b_swap_rd", 1, rd_v[1], 32'h96);

    // rst after four ticks
    wr_b = 8'h77;
    start_v[1] = 1'b1;
    nt = 0; rk = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rk != 0 && k == rk + 1) begin
        chk("b_rst_tick", 1, tick_v[1], 0);
        chk("b_rst_busy", 1, busy_v[1], 0);
        chk("b_rst_rd", 1, rd_v[1], 0);
        rst_v[1] = 1'b0;
      end
      if (rk == 0 && tick_v[1]) begin
        nt++;
        if (nt == 4) begin
          rst_v[1] = 1'b1;
          rk = k;
        end
      end
      if (k == 1) start_v[1] = 1'b0;
    end
    rst_v[1] = 1'b0;
    chk("b_rst_at", 1, rk, 12);
    wr_b = 8'h3C;
    run_pass(1, 35, 0, 0, nt, nd, dc, ft, bad, sq);
    chk("b_fresh_ticks", 1, nt, 10);
    chk("b_fresh_chain", 1, phases_of(ch[1], 2), 32'h3C);

    // N=8 back-to-back swaps
    prev = '0;
    for (int p = 0; p < 50; p++) begin
      wr_c = $urandom;
      run_pass(2, 165, 0, 0, nt, nd, dc, ft, bad, sq);
      chk("c_ticks", 2, nt, 40);
      chk("c_done", 2, nd, 1);
      chk("c_swap_rd", 2, rd_v[2], prev);
      prev = wr_c;
    end
    chk("c_chain", 2, phases_of(ch[2], 8), prev);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
